// File: rtl/l1_llc_arbiter.sv
// N-to-1 L1/LLC interconnect: round-robin request arbiter with a registered
// LLC request slot, plus an owner FIFO that routes in-order fills back.
module l1_llc_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int PADDR_BITS      = 19,
  parameter int LINE_BITS       = 512,
  parameter int MAX_OUTSTANDING = 8,
  parameter int PORT_BITS       = $clog2(NUM_PORTS)
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_PORTS-1:0]            l1_valid_in,
  output logic [NUM_PORTS-1:0]            l1_ready_out,
  input  logic [NUM_PORTS*PADDR_BITS-1:0] l1_addr_in,
  input  logic [NUM_PORTS-1:0]            l1_we_in,
  input  logic [NUM_PORTS*LINE_BITS-1:0]  l1_line_in,
  output logic [NUM_PORTS-1:0]            l1_resp_valid_out,
  input  logic [NUM_PORTS-1:0]            l1_resp_ready_in,
  output logic [PADDR_BITS-1:0]           l1_resp_addr_out,
  output logic [LINE_BITS-1:0]            l1_resp_line_out,
  output logic                            llc_valid_out,
  input  logic                            llc_ready_in,
  output logic [PADDR_BITS-1:0]           llc_addr_out,
  output logic                            llc_we_out,
  output logic [LINE_BITS-1:0]            llc_line_out,
  input  logic                            llc_resp_valid_in,
  output logic                            llc_resp_ready_out,
  input  logic [PADDR_BITS-1:0]           llc_resp_addr_in,
  input  logic [LINE_BITS-1:0]            llc_resp_line_in,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_out,
  output logic                            err_out
);

  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int CW = AW + 1;

  logic [PORT_BITS-1:0] rr_ptr;
  logic [PORT_BITS-1:0] gnt_idx;
  logic                 gnt;
  logic                 slot_free;
  logic [NUM_PORTS-1:0] elig;
  logic [PORT_BITS:0]   sum;
  logic [PORT_BITS-1:0] cand;

  logic [PADDR_BITS-1:0] gnt_addr;
  logic                  gnt_we;
  logic [LINE_BITS-1:0]  gnt_line;

  logic [PORT_BITS-1:0] owner_q [MAX_OUTSTANDING];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic [PORT_BITS-1:0] head;
  logic                 push;
  logic                 pop;

  assign full      = (count == CW'(MAX_OUTSTANDING));
  assign empty     = (count == '0);
  assign slot_free = !llc_valid_out || llc_ready_in;
  assign elig      = l1_valid_in & (l1_we_in | {NUM_PORTS{!full}});

  // first eligible port at or after rr_ptr, wrapping modulo NUM_PORTS
  always_comb begin
    gnt          = 1'b0;
    gnt_idx      = '0;
    sum          = '0;
    cand         = '0;
    l1_ready_out = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sum = {1'b0, rr_ptr} + (PORT_BITS+1)'(k);
      if (sum >= (PORT_BITS+1)'(NUM_PORTS))
        sum = sum - (PORT_BITS+1)'(NUM_PORTS);
      cand = sum[PORT_BITS-1:0];
      if (!gnt && slot_free && elig[cand]) begin
        gnt     = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt)
      l1_ready_out[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_addr = '0;
    gnt_we   = 1'b0;
    gnt_line = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_idx == PORT_BITS'(i)) begin
        gnt_addr = l1_addr_in[i*PADDR_BITS +: PADDR_BITS];
        gnt_we   = l1_we_in[i];
        gnt_line = l1_line_in[i*LINE_BITS +: LINE_BITS];
      end
    end
  end

  assign head = owner_q[rd_ptr];
  assign push = gnt && !gnt_we;
  assign pop  = llc_resp_valid_in && llc_resp_ready_out && !empty;

  always_comb begin
    l1_resp_valid_out = '0;
    if (llc_resp_valid_in && !empty)
      l1_resp_valid_out[head] = 1'b1;
  end

  assign llc_resp_ready_out = empty || l1_resp_ready_in[head];
  assign l1_resp_addr_out   = llc_resp_addr_in;
  assign l1_resp_line_out   = llc_resp_line_in;
  assign outstanding_out    = count;

  always_ff @(posedge clk_in) begin
    if (push)
      owner_q[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      llc_valid_out <= 1'b0;
      llc_addr_out  <= '0;
      llc_we_out    <= 1'b0;
      llc_line_out  <= '0;
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_out       <= 1'b0;
    end else begin
      if (gnt) begin
        llc_valid_out <= 1'b1;
        llc_addr_out  <= gnt_addr;
        llc_we_out    <= gnt_we;
        llc_line_out  <= gnt_line;
        rr_ptr <= (gnt_idx == PORT_BITS'(NUM_PORTS-1))
                  ? '0 : gnt_idx + PORT_BITS'(1);
      end else if (llc_ready_in) begin
        llc_valid_out <= 1'b0;
      end
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
      // a fill with nobody waiting is dropped and flagged until reset
      if (llc_resp_valid_in && empty)
        err_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_llc_arbiter.sv
// Bench for l1_llc_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_l1_llc_arbiter;

  localparam int N  = 4;
  localparam int PA = 19;
  localparam int LB = 512;
  localparam int MO = 8;
  localparam int CW = $clog2(MO) + 1;

  logic            clk_in = 1'b0;
  logic            rst_in;
  logic [N-1:0]    l1_valid_in;
  logic [N-1:0]    l1_ready_out;
  logic [N*PA-1:0] l1_addr_in;
  logic [N-1:0]    l1_we_in;
  logic [N*LB-1:0] l1_line_in;
  logic [N-1:0]    l1_resp_valid_out;
  logic [N-1:0]    l1_resp_ready_in;
  logic [PA-1:0]   l1_resp_addr_out;
  logic [LB-1:0]   l1_resp_line_out;
  logic            llc_valid_out;
  logic            llc_ready_in;
  logic [PA-1:0]   llc_addr_out;
  logic            llc_we_out;
  logic [LB-1:0]   llc_line_out;
  logic            llc_resp_valid_in;
  logic            llc_resp_ready_out;
  logic [PA-1:0]   llc_resp_addr_in;
  logic [LB-1:0]   llc_resp_line_in;
  logic [CW-1:0]   outstanding_out;
  logic            err_out;

  l1_llc_arbiter #(
    .NUM_PORTS(N), .PADDR_BITS(PA), .LINE_BITS(LB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .l1_valid_in(l1_valid_in), .l1_ready_out(l1_ready_out),
    .l1_addr_in(l1_addr_in), .l1_we_in(l1_we_in),
    .l1_line_in(l1_line_in),
    .l1_resp_valid_out(l1_resp_valid_out),
    .l1_resp_ready_in(l1_resp_ready_in),
    .l1_resp_addr_out(l1_resp_addr_out),
    .l1_resp_line_out(l1_resp_line_out),
    .llc_valid_out(llc_valid_out), .llc_ready_in(llc_ready_in),
    .llc_addr_out(llc_addr_out), .llc_we_out(llc_we_out),
    .llc_line_out(llc_line_out),
    .llc_resp_valid_in(llc_resp_valid_in),
    .llc_resp_ready_out(llc_resp_ready_out),
    .llc_resp_addr_in(llc_resp_addr_in),
    .llc_resp_line_in(llc_resp_line_in),
    .outstanding_out(outstanding_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  bit            m_valid;
  logic [PA-1:0] m_addr;
  bit            m_we;
  logic [LB-1:0] m_line;
  int            rr;
  int            q[$];
  bit            m_err;

  task automatic chk(string name, logic [LB-1:0] act, logic [LB-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [LB-1:0] rand_line();
    logic [LB-1:0] l;
    for (int i = 0; i < LB/32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int pick();
    bit full;
    int p;
    full = (q.size() >= MO);
    if (m_valid && !llc_ready_in) return -1;
    for (int k = 0; k < N; k++) begin
      p = (rr + k) % N;
      if (l1_valid_in[p] && (l1_we_in[p] || !full)) return p;
    end
    return -1;
  endfunction

  // check at mid-cycle, advance the model on the edge, return at negedge
  task automatic cycle();
    int g;
    logic [N-1:0] er;
    logic [N-1:0] erv;
    bit ers;
    #1;
    g = pick();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    erv = '0;
    if (llc_resp_valid_in && q.size() > 0) erv[q[0]] = 1'b1;
    ers = (q.size() == 0) || l1_resp_ready_in[q[0]];
    chk("l1_ready", l1_ready_out, er);
    chk("resp_valid", l1_resp_valid_out, erv);
    chk("resp_ready", llc_resp_ready_out, ers);
    chk("resp_addr", l1_resp_addr_out, llc_resp_addr_in);
    chk("resp_line", l1_resp_line_out, llc_resp_line_in);
    chk("llc_valid", llc_valid_out, m_valid);
    if (m_valid) begin
      chk("llc_addr", llc_addr_out, m_addr);
      chk("llc_we", llc_we_out, m_we);
      chk("llc_line", llc_line_out, m_line);
    end
    chk("outstanding", outstanding_out, q.size());
    chk("err", err_out, m_err);
    @(posedge clk_in);
    if (rst_in) begin
      m_valid = 0; m_addr = '0; m_we = 0; m_line = '0;
      rr = 0; q.delete(); m_err = 0;
    end else begin
      if (llc_resp_valid_in && q.size() == 0) m_err = 1;
      if (llc_resp_valid_in && q.size() > 0 && ers) void'(q.pop_front());
      if (g >= 0) begin
        m_valid = 1;
        m_addr  = l1_addr_in[g*PA +: PA];
        m_we    = l1_we_in[g];
        m_line  = l1_line_in[g*LB +: LB];
        if (!m_we) q.push_back(g);
        rr = (g + 1) % N;
      end else if (llc_ready_in) begin
        m_valid = 0;
      end
    end
    @(negedge clk_in);
  endtask

  task automatic idle();
    l1_valid_in       = '0;
    l1_we_in          = '0;
    l1_addr_in        = '0;
    l1_line_in        = '0;
    l1_resp_ready_in  = '1;
    llc_ready_in      = 1'b1;
    llc_resp_valid_in = 1'b0;
    llc_resp_addr_in  = '0;
    llc_resp_line_in  = '0;
  endtask

  task automatic set_req(int p, bit we, logic [PA-1:0] a);
    l1_valid_in[p]          = 1'b1;
    l1_we_in[p]             = we;
    l1_addr_in[p*PA +: PA]  = a;
    l1_line_in[p*LB +: LB]  = rand_line();
  endtask

  task automatic randomize_inputs();
    rst_in       = ($urandom_range(0, 199) == 0);
    l1_valid_in  = N'($urandom);
    for (int p = 0; p < N; p++) begin
      l1_we_in[p]            = ($urandom_range(0, 3) == 0);
      l1_addr_in[p*PA +: PA] = PA'($urandom);
      l1_line_in[p*LB +: LB] = rand_line();
      l1_resp_ready_in[p]    = ($urandom_range(0, 9) < 8);
    end
    llc_ready_in      = ($urandom_range(0, 9) < 7);
    llc_resp_valid_in = (q.size() > 0) ? ($urandom_range(0, 9) < 4)
                                       : ($urandom_range(0, 99) < 3);
    llc_resp_addr_in  = PA'($urandom);
    llc_resp_line_in  = rand_line();
  endtask

  logic [PA-1:0] bp_addr;

  initial begin
    idle();
    rst_in = 1'b1;
    @(negedge clk_in);
    m_valid = 0; m_addr = '0; m_we = 0; m_line = '0;
    rr = 0; m_err = 0;
    cycle();
    cycle();
    rst_in = 1'b0;
    chk("rst_llc_valid", llc_valid_out, 1'b0);
    chk("rst_llc_addr", llc_addr_out, '0);
    chk("rst_outstanding", outstanding_out, '0);
    chk("rst_err", err_out, 1'b0);

    // single read from port 2
    set_req(2, 0, 19'h1A2B3);
    #1 chk("single_grant", l1_ready_out, 4'b0100);
    cycle();
    l1_valid_in = '0;
    chk("single_llc_valid", llc_valid_out, 1'b1);
    chk("single_llc_addr", llc_addr_out, 19'h1A2B3);
    chk("single_llc_we", llc_we_out, 1'b0);
    chk("single_outstanding", outstanding_out, 1);
    llc_resp_valid_in = 1'b1;
    llc_resp_addr_in  = 19'h1A2B3;
    #1 chk("single_route", l1_resp_valid_out, 4'b0100);
    cycle();
    llc_resp_valid_in = 1'b0;
    chk("single_drain", outstanding_out, 0);

    // round robin from reset until the owner FIFO fills
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < N; p++) set_req(p, 0, PA'($urandom));
      #1 chk("rr_grant", l1_ready_out, 4'(1) << (k % 4));
      cycle();
    end
    chk("full_count", outstanding_out, 8);
    #1 chk("full_block", l1_ready_out, 4'b0000);
    cycle();
    l1_we_in[1] = 1'b1;
    #1 chk("full_wb_grant", l1_ready_out, 4'b0010);
    cycle();
    l1_we_in = '0;
    chk("full_wb_we", llc_we_out, 1'b1);
    llc_resp_valid_in = 1'b1;
    #1 chk("route0", l1_resp_valid_out, 4'b0001);
    chk("full_same_cycle", l1_ready_out, 4'b0000);
    cycle();
    llc_resp_valid_in = 1'b0;
    #1 chk("full_freed", l1_ready_out, 4'b0100);
    cycle();
    l1_valid_in = '0;
    for (int k = 1; k <= 6; k++) begin
      llc_resp_valid_in = 1'b1;
      #1 chk("route_order", l1_resp_valid_out, 4'(1) << (k % 4));
      cycle();
    end

    // fill for port 3 stalled by the L1
    l1_resp_ready_in[3] = 1'b0;
    #1 chk("stall_ready", llc_resp_ready_out, 1'b0);
    for (int k = 0; k < 3; k++) cycle();
    chk("stall_count", outstanding_out, 2);
    l1_resp_ready_in = '1;
    cycle();
    cycle();
    llc_resp_valid_in = 1'b0;
    chk("stall_drain", outstanding_out, 0);

    // backpressure holds the slot and payload
    bp_addr = 19'h5C0DE;
    set_req(1, 0, bp_addr);
    llc_ready_in = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_addr", llc_addr_out, bp_addr);
      cycle();
    end
    llc_ready_in = 1'b1;
    #1 chk("bp_release", l1_ready_out, 4'b0010);
    cycle();
    l1_valid_in = '0;
    cycle();

    // fill with nobody waiting, then reset mid-transfer
    llc_resp_valid_in = 1'b1;
    cycle();
    cycle();
    cycle();
    llc_resp_valid_in = 1'b0;
    chk("err_set", err_out, 1'b1);
    cycle();
    chk("err_sticky", err_out, 1'b1);
    set_req(0, 1, 19'h7FFFF);
    llc_ready_in = 1'b0;
    cycle();
    rst_in = 1'b1;
    cycle();
    rst_in = 1'b0;
    l1_valid_in = '0;
    chk("rst_mid_valid", llc_valid_out, 1'b0);
    chk("rst_mid_err", err_out, 1'b0);
    chk("rst_mid_count", outstanding_out, 0);

    for (int c = 0; c < 3000; c++) begin
      randomize_inputs();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/l1_llc_arbiter.md
Name: l1_llc_arbiter

Overview:
- Parametrised N-to-1 interconnect between NUM_PORTS L1 caches (lower-cache side) and one last-level cache (higher-cache side).
- Round-robin arbitrates line requests from the L1s onto a single registered LLC request channel.
- Tracks the owner of each outstanding read and routes in-order LLC fill responses back to the requesting L1.
- Replaces the fixed single-L1 point-to-point hookup; supports multiple cores, writebacks and bounded outstanding reads.

Parameters:
NUM_PORTS, 4, number of L1 requesters (≥2)
PADDR_BITS, 19, line address width
LINE_BITS, 512, cache line width in bits
MAX_OUTSTANDING, 8, depth of owner FIFO (power of two)
PORT_BITS, $clog2(NUM_PORTS), owner ID width (derived)

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
l1_valid_in  in  NUM_PORTS  per-port request valid
l1_ready_out  out  NUM_PORTS  per-port request accepted (combinational)
l1_addr_in  in  NUM_PORTS*PADDR_BITS  per-port line address, port i at [i*PADDR_BITS +: PADDR_BITS]
l1_we_in  in  NUM_PORTS  1 = writeback (carries line), 0 = read fill
l1_line_in  in  NUM_PORTS*LINE_BITS  per-port writeback data
l1_resp_valid_out  out  NUM_PORTS  fill response valid to port
l1_resp_ready_in  in  NUM_PORTS  port can take fill
l1_resp_addr_out  out  PADDR_BITS  fill address (shared bus)
l1_resp_line_out  out  LINE_BITS  fill data (shared bus)
llc_valid_out  out  1  registered request to LLC
llc_ready_in  in  1  LLC accepts request
llc_addr_out  out  PADDR_BITS  request address
llc_we_out  out  1  request is writeback
llc_line_out  out  LINE_BITS  writeback data
llc_resp_valid_in  in  1  LLC fill valid
llc_resp_ready_out  out  1  arbiter can take fill
llc_resp_addr_in  in  PADDR_BITS  fill address
llc_resp_line_in  in  LINE_BITS  fill data
outstanding_out  out  $clog2(MAX_OUTSTANDING)+1  reads in flight
err_out  out  1  sticky: fill received with no owner

Behaviour:
- Reset (rst_in high at posedge): llc_valid_out=0, llc_addr/we/line=0, RR pointer=0, owner FIFO empty, outstanding_out=0, err_out=0. All in-flight state discarded; fills arriving after reset with empty FIFO set err_out.
- Request slot: one output register. Slot is free when llc_valid_out=0 or (llc_valid_out & llc_ready_in) this cycle.
- Eligibility: port i eligible if l1_valid_in[i] and (l1_we_in[i]=1 or owner FIFO not full). Full means count==MAX_OUTSTANDING at start of cycle; a same-cycle dequeue does NOT free space for a read enqueue.
- Grant: if slot free, pick first eligible port searching from RR pointer upward, wrapping modulo NUM_PORTS. Exactly one l1_ready_out bit high for that port; all others 0. No grant when slot busy or none eligible.
- On grant: next cycle llc_valid_out=1 with captured addr/we/line; RR pointer = granted+1 (wraps to 0). Read grants push owner ID into the FIFO in the same edge. Latency accept→llc_valid_out = 1 cycle; back-to-back grants every cycle while llc_ready_in=1.
- Hold: llc_valid_out and payload stable while llc_ready_in=0.
- Response routing (combinational): head = FIFO head owner. l1_resp_valid_out[head] = llc_resp_valid_in & !empty; others 0. l1_resp_addr/line_out = llc_resp_addr/line_in. llc_resp_ready_out = empty | l1_resp_ready_in[head].
- Pop on llc_resp_valid_in & llc_resp_ready_out & !empty. If llc_resp_valid_in while empty: fill consumed/dropped, err_out set and held until reset.
- outstanding_out = FIFO count: +1 on read grant, −1 on pop, unchanged when both occur in the same cycle. FIFO pointers wrap modulo MAX_OUTSTANDING.
- Writebacks never enqueue and never expect a fill.

Test Plan:
- Single read: port 2 requests addr 0x1A2B3, llc_ready_in=1 → l1_ready_out=4'b0100 same cycle; next cycle llc_valid_out=1, addr 0x1A2B3, we=0; outstanding_out=1; fill 0x1A2B3 → only l1_resp_valid_out[2]=1, outstanding_out=0.
- Round robin: all 4 ports request reads continuously, llc_ready_in=1 → grant order 0,1,2,3,0,…; in-order fills route to 0,1,2,3.
- Backpressure: llc_ready_in=0 for 5 cycles with request held → payload stable, no further grants; llc_ready_in=1 → next grant the same cycle.
- Full: 8 reads outstanding, no fills → read requests get no ready; a writeback from port 1 still granted with we=1; a fill frees one slot only from the following cycle.
- Response stall: fill for port 3 with l1_resp_ready_in[3]=0 → llc_resp_ready_out=0, FIFO unchanged until ready.
- Error/reset: fill with empty FIFO → err_out=1 sticky; rst_in mid-transfer → all outputs 0 next cycle, err_out=0.
